// File: rtl/nand_flash_resp.sv
`default_nettype none
// ============================================================================
// Module   : nand_flash_resp
// Brief    : Small-page NAND flash responder (read, program, erase, reset)
//            with 512-byte page buffer, busy timing and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module nand_flash_resp #(
  parameter int ADDR_W  = 18,
  parameter int T_READ  = 4,
  parameter int T_PROG  = 8,
  parameter int T_ERASE = 8,
  parameter int T_RST   = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB,
  output logic       err
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_R_ADDR, S_R_BUSY, S_R_DATA, S_P_ADDR, S_P_DATA,
    S_P_BUSY, S_E_ADDR, S_E_BUSY, S_WAIT, S_RST_BUSY
  } state_t;

  state_t      r_state, w_state_n;
  logic        r_wen_q, r_ren_q;
  logic        r_ptr, w_ptr_n;
  logic [9:0]  r_col, w_col_n, w_col_a;
  logic [8:0]  r_page, w_page_n, w_page_a;
  logic [1:0]  r_acnt, w_acnt_n;
  logic [11:0] r_timer, w_timer_n;
  logic [10:0] r_idx, w_idx_n;
  logic        r_err, w_err_n;
  logic        r_rb, w_rb_n;
  logic [511:0] r_bvalid;
  logic [7:0]  r_buf [0:511];
  logic [7:0]  r_mem [0:c_DEPTH-1];

  logic        w_buf_clr, w_buf_we, w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr, w_rd_addr;
  logic [7:0]  w_mem_wdata, w_rdata, w_bufbyte, w_io;
  logic        w_we_rise, w_re_rise, w_cmd, w_adr, w_dat, w_bad;

  assign w_io      = F_IO;
  assign w_we_rise = F_WEN & ~r_wen_q;
  assign w_re_rise = F_REN & ~r_ren_q;
  assign w_cmd     = w_we_rise &  F_CLE & ~F_ALE;
  assign w_adr     = w_we_rise & ~F_CLE &  F_ALE;
  assign w_dat     = w_we_rise & ~F_CLE & ~F_ALE;
  assign w_bad     = w_we_rise &  F_CLE &  F_ALE;

  assign w_rd_addr = ADDR_W'({r_page, r_col[8:0]});
  assign w_rdata   = r_col[9] ? 8'hFF : r_mem[w_rd_addr];
  assign F_IO      = (r_state == S_R_DATA && !F_REN) ? w_rdata : 8'bz;
  assign F_RB      = r_rb;
  assign err       = r_err;

  // Unwritten buffer bytes read as FFh so the commit AND leaves them untouched
  assign w_bufbyte = r_bvalid[r_idx[8:0]] ? r_buf[r_idx[8:0]] : 8'hFF;

  // Address cycle counter 0..2 maps to A[7:0], A[16:9], A[17]; erase starts at 1
  always_comb begin
    w_col_a  = r_col;
    w_page_a = r_page;
    case (r_acnt)
      2'd0:    w_col_a = {1'b0, r_ptr, w_io};
      2'd1:    w_page_a[7:0] = w_io;
      default: w_page_a[8] = w_io[0];
    endcase
  end

  always_comb begin
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_col_n     = r_col;
    w_page_n    = r_page;
    w_acnt_n    = r_acnt;
    w_timer_n   = r_timer;
    w_idx_n     = r_idx;
    w_err_n     = r_err | w_bad;
    w_rb_n      = r_rb;
    w_buf_clr   = 1'b0;
    w_buf_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = 8'hFF;

    if (w_cmd && w_io == 8'hFF) begin
      w_state_n = S_RST_BUSY;
      w_rb_n    = 1'b0;
      w_timer_n = 12'(T_RST);
      w_err_n   = 1'b0;
      w_buf_clr = 1'b1;
    end else begin
      // Busy states never decode commands, so flag them here and keep running
      if (w_cmd && !r_rb) w_err_n = 1'b1;
      case (r_state)
        S_IDLE, S_R_ADDR, S_R_DATA: begin
          if (w_cmd) begin
            w_acnt_n = 2'd0;
            case (w_io)
              8'h00, 8'h01: begin w_ptr_n = w_io[0]; w_state_n = S_R_ADDR; end
              8'h80:        begin w_buf_clr = 1'b1; w_state_n = S_P_ADDR; end
              8'h60:        begin w_acnt_n = 2'd1; w_state_n = S_E_ADDR; end
              default:      begin w_err_n = 1'b1; w_state_n = S_IDLE; end
            endcase
          end else if (w_adr && r_state == S_R_ADDR) begin
            w_col_n  = w_col_a;
            w_page_n = w_page_a;
            w_acnt_n = r_acnt + 2'd1;
            if (r_acnt == 2'd2) begin
              w_state_n = S_R_BUSY;
              w_rb_n    = 1'b0;
              w_timer_n = 12'(T_READ);
            end
          end else if (w_adr || w_dat) begin
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end else if (r_state == S_R_DATA && w_re_rise) begin
            if (r_col[9]) w_err_n = 1'b1;
            else          w_col_n = r_col + 10'd1;
          end
        end
        S_P_ADDR: begin
          if (w_adr) begin
            w_col_n  = w_col_a;
            w_page_n = w_page_a;
            w_acnt_n = r_acnt + 2'd1;
            if (r_acnt == 2'd2) w_state_n = S_P_DATA;
          end else if (w_cmd || w_dat) begin
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        S_P_DATA: begin
          if (w_dat) begin
            if (r_col[9]) begin
              w_err_n = 1'b1;
            end else begin
              w_buf_we = 1'b1;
              w_col_n  = r_col + 10'd1;
            end
          end else if (w_cmd) begin
            if (w_io == 8'h10) begin
              w_state_n = S_P_BUSY;
              w_rb_n    = 1'b0;
              w_idx_n   = '0;
            end else begin
              w_err_n   = 1'b1;
              w_buf_clr = 1'b1;
              w_state_n = S_IDLE;
            end
          end else if (w_adr) begin
            w_err_n = 1'b1;
          end
        end
        S_E_ADDR: begin
          if (w_adr) begin
            if (r_acnt == 2'd3) begin
              w_err_n = 1'b1;
            end else begin
              w_page_n = w_page_a;
              w_acnt_n = r_acnt + 2'd1;
            end
          end else if (w_cmd) begin
            if (w_io == 8'hD0 && r_acnt == 2'd3) begin
              w_state_n = S_E_BUSY;
              w_rb_n    = 1'b0;
              w_idx_n   = '0;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = S_IDLE;
            end
          end else if (w_dat) begin
            w_err_n = 1'b1;
          end
        end
        S_P_BUSY: begin
          w_mem_we    = 1'b1;
          w_mem_waddr = ADDR_W'({r_page, r_idx[8:0]});
          w_mem_wdata = r_mem[w_mem_waddr] & w_bufbyte;
          w_idx_n     = r_idx + 11'd1;
          if (r_idx[8:0] == 9'h1FF) begin
            w_state_n = S_WAIT;
            w_timer_n = 12'(T_PROG);
          end
        end
        S_E_BUSY: begin
          w_mem_we    = 1'b1;
          w_mem_waddr = ADDR_W'({r_page[8:2], r_idx});
          w_idx_n     = r_idx + 11'd1;
          if (r_idx == 11'h7FF) begin
            w_state_n = S_WAIT;
            w_timer_n = 12'(T_ERASE);
          end
        end
        S_R_BUSY, S_WAIT, S_RST_BUSY: begin
          if (r_timer <= 12'd1) begin
            w_rb_n    = 1'b1;
            w_timer_n = '0;
            if (r_state == S_R_BUSY) begin
              w_state_n = S_R_DATA;
            end else begin
              w_state_n = S_IDLE;
              w_ptr_n   = 1'b0;
              if (r_state == S_RST_BUSY) begin
                w_err_n = 1'b0;
                w_col_n = '0;
              end
            end
          end else begin
            w_timer_n = r_timer - 12'd1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wen_q  <= 1'b1;
      r_ren_q  <= 1'b1;
      r_ptr    <= 1'b0;
      r_col    <= '0;
      r_page   <= '0;
      r_acnt   <= '0;
      r_timer  <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_rb     <= 1'b1;
      r_bvalid <= '0;
    end else begin
      r_state  <= w_state_n;
      r_wen_q  <= F_WEN;
      r_ren_q  <= F_REN;
      r_ptr    <= w_ptr_n;
      r_col    <= w_col_n;
      r_page   <= w_page_n;
      r_acnt   <= w_acnt_n;
      r_timer  <= w_timer_n;
      r_idx    <= w_idx_n;
      r_err    <= w_err_n;
      r_rb     <= w_rb_n;
      if (w_buf_clr)     r_bvalid <= '0;
      else if (w_buf_we) r_bvalid[r_col[8:0]] <= 1'b1;
    end
  end

  // Array and buffer storage are not reset; contents survive rst
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    if (w_buf_we) r_buf[r_col[8:0]] <= w_io;
  end

endmodule
`default_nettype wire
